grf_nr_clr: RTL and testbench
=============================

# grf_nr_clr

Parametrised register file with one write port and N read ports, the next generation of the CPU general register file. It adds configurable data width, depth and read-port count, byte-lane write merging, optional write-to-read bypass, an optional hard-wired zero register, and a reset-driven clear sequencer. This sequencer zeroes every entry after reset and flags the file busy meanwhile. The block sits in the decode/execute stage, feeding operand reads and taking writeback.

## Interface
- DATA_W, 32: data width; multiple of 8; NBYTE = DATA_W/8
- ADDR_W, 4: address width; DEPTH = 2^ADDR_W
- NRD, 2: number of read ports, 1..4
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports
- ZERO_R0, 0: 1 = entry 0 reads as zero; writes to it are discarded
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_clk_en  in  1  clock enable for writes and clear-sequencer advance
- i_cs_b  in  1  active-low write chip select
- i_waddr  in  ADDR_W  write address
- i_wen  in  NBYTE  per-byte write enables; bit k covers din[8k+7:8k]
- i_din  in  DATA_W  write data
- i_raddr  in  NRD*ADDR_W  read addresses; port p at [p*ADDR_W +: ADDR_W]
- o_dout  out  NRD*DATA_W  read data; port p at [p*DATA_W +: DATA_W]; combinational
- o_busy  out  1  high while the clear sequence runs; registered

## Operation
- Write qualifier: wr = i_clk_en & !i_cs_b & |i_wen & !o_busy & !(ZERO_R0 & i_waddr==0).
- Merged word: byte k = i_wen[k] ? i_din byte k : rf[i_waddr] byte k. When wr is true, rf[i_waddr] <= merged word.
- Read port p, in priority order:
  - o_busy -> 0
  - ZERO_R0 & raddr==0 -> 0
  - BYPASS & wr & raddr==i_waddr -> merged word
  - otherwise rf[raddr]
- Any combination of read ports may share an address, including with each other and with the write address.
- Clear sequencer FSM, states IDLE and CLEAR, with pointer ptr[ADDR_W]:
  - i_rst (overrides everything, ignores i_clk_en): state <= CLEAR, ptr <= 0, o_busy <= 1.
  - CLEAR with i_clk_en: rf[ptr] <= 0 and ptr <= ptr+1. When ptr == DEPTH-1, state <= IDLE and o_busy <= 0. The ptr wraps to 0.
  - CLEAR with !i_clk_en: hold.
  - IDLE: ptr holds 0.
- Writes presented during CLEAR are dropped silently; no queueing.
- Reset mid-clear restarts the sequence from ptr 0.

## Timing
- Reset values: o_busy = 1, state = CLEAR, ptr = 0. All o_dout = 0 while busy.
- Clear length: exactly DEPTH enabled cycles after the first cycle i_rst is low. o_busy falls on the edge that clears entry DEPTH-1.
- Write latency: data is in the array one edge after wr. It is visible the same cycle via bypass (BYPASS=1), or the next cycle otherwise.
- Read latency: zero cycles (combinational from i_raddr, array and write inputs).
- With BYPASS=0, a read of the address being written returns the old value that cycle.
- No combinational path from i_rst to outputs. o_busy is registered.

## Test plan
- Reset, default params: hold i_rst 2 cycles, then release with i_clk_en=1. o_busy stays high for exactly 16 cycles and all o_dout read 0. Afterwards every entry reads 0x00000000.
- Byte merge: write R3=0x11223344 with wen=4'hF, then wen=4'b0101 with din 0xAABBCCDD. R3 reads 0x11BB33DD next cycle.
- Bypass: BYPASS=1, write R5=0xDEADBEEF with all read ports on R5. All ports read 0xDEADBEEF in the same cycle. With BYPASS=0 the same stimulus gives the old value, then 0xDEADBEEF.
- Gating: a write with i_cs_b=1, i_clk_en=0, wen=0, or during o_busy leaves the target unchanged. ZERO_R0=1 with a write of R0=0xFFFFFFFF still reads 0.
- Mid-clear reset and clk_en stalls: assert i_rst at ptr=7, then release. busy lasts 16 more enabled cycles. Toggling i_clk_en low for 3 cycles extends busy by 3.
- Params DATA_W=16, ADDR_W=3, NRD=4: random writes and reads against a reference model for 2000 cycles with zero mismatches, with the clear covering 8 entries.

Source files
------------

// File: rtl/grf_nr_clr.sv
// Parametrised general register file: one byte-merging write port, NRD combinational read
// ports, optional write-to-read bypass and zero register, and a clear sequencer run after reset.
module grf_nr_clr #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 4,
   parameter int NRD     = 2,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clk_en,
   input  logic                    i_cs_b,
   input  logic [ADDR_W-1:0]       i_waddr,
   input  logic [DATA_W/8-1:0]     i_wen,
   input  logic [DATA_W-1:0]       i_din,
   input  logic [NRD*ADDR_W-1:0]   i_raddr,
   output logic [NRD*DATA_W-1:0]   o_dout,
   output logic                    o_busy
);

   localparam int NBYTE = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   rf_q [DEPTH];
   logic [DATA_W-1:0]   rf_d [DEPTH];

   logic                clr_en;
   logic                zero_hit;
   logic                wr;
   logic [DATA_W-1:0]   merged;

   // Byte lanes with their enable set take the new data, the rest keep the stored word.
   function automatic logic [DATA_W-1:0] merge_bytes(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] new_word,
      input logic [NBYTE-1:0]  lane_en
   );
      logic [DATA_W-1:0] res;
      res = old_word;
      for (int k = 0; k < NBYTE; k++) begin
         if (lane_en[k]) begin
            res[k*8 +: 8] = new_word[k*8 +: 8];
         end else begin
            res[k*8 +: 8] = old_word[k*8 +: 8];
         end
      end
      return res;
   endfunction

   assign zero_hit = ZERO_R0 && (i_waddr == PTR_ZERO);
   assign wr       = i_clk_en && !i_cs_b && (|i_wen) && !busy_q && !zero_hit;
   assign merged   = merge_bytes(rf_q[i_waddr], i_din, i_wen);
   assign o_busy   = busy_q;

   // Clear sequencer: walks the pointer through every entry once per reset.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      busy_d  = busy_q;
      clr_en  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            if (i_clk_en) begin
               clr_en = 1'b1;
               ptr_d  = ptr_q + PTR_ONE;
               if (ptr_q == PTR_LAST) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_CLEAR;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = ST_CLEAR;
               busy_d  = 1'b1;
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
            ptr_d   = PTR_ZERO;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = PTR_ZERO;
            busy_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_CLEAR;
         ptr_q   <= PTR_ZERO;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   // Clear and write are mutually exclusive because writes are blocked while busy.
   always_comb begin
      rf_d = rf_q;
      if (clr_en) begin
         rf_d[ptr_q] = {DATA_W{1'b0}};
      end else if (wr) begin
         rf_d[i_waddr] = merged;
      end else begin
         rf_d = rf_q;
      end
   end

   always_ff @(posedge i_clk) begin
      rf_q <= rf_d;
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = i_raddr[p*ADDR_W +: ADDR_W];

      // Read priority: busy blanking, zero register, same-cycle forwarding, stored entry.
      always_comb begin
         if (busy_q) begin
            rd = {DATA_W{1'b0}};
         end else if (ZERO_R0 && (ra == PTR_ZERO)) begin
            rd = {DATA_W{1'b0}};
         end else if (BYPASS && wr && (ra == i_waddr)) begin
            rd = merged;
         end else begin
            rd = rf_q[ra];
         end
      end

      assign o_dout[p*DATA_W +: DATA_W] = rd;
   end

endmodule

// File: tb/tb_grf_nr_clr.sv
// Scoreboard bench: three instances (bypass/no-zero, no-bypass/zero-R0, narrow 4-port) checked
// by a negedge monitor that pops expected read values and busy flags pushed by the stimulus.
module tb_grf_nr_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // shared inputs for the two 32-bit instances
   logic        rst = 1'b1, clk_en = 1'b1, cs_b = 1'b1;
   logic [3:0]  waddr = 4'h0, wen = 4'h0;
   logic [31:0] din = 32'h0;
   logic [7:0]  raddr = 8'h0;
   logic [63:0] dout_a, dout_b;
   logic        busy_a, busy_b;

   // narrow instance inputs
   logic        rst_c = 1'b1, clk_en_c = 1'b1, cs_b_c = 1'b1;
   logic [2:0]  waddr_c = 3'h0;
   logic [1:0]  wen_c = 2'h0;
   logic [15:0] din_c = 16'h0;
   logic [11:0] raddr_c = 12'h0;
   logic [63:0] dout_c;
   logic        busy_c;

   grf_nr_clr #(.DATA_W(32), .ADDR_W(4), .NRD(2), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_cs_b(cs_b), .i_waddr(waddr),
      .i_wen(wen), .i_din(din), .i_raddr(raddr), .o_dout(dout_a), .o_busy(busy_a));

   grf_nr_clr #(.DATA_W(32), .ADDR_W(4), .NRD(2), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_cs_b(cs_b), .i_waddr(waddr),
      .i_wen(wen), .i_din(din), .i_raddr(raddr), .o_dout(dout_b), .o_busy(busy_b));

   grf_nr_clr #(.DATA_W(16), .ADDR_W(3), .NRD(4), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut_c (
      .i_clk(clk), .i_rst(rst_c), .i_clk_en(clk_en_c), .i_cs_b(cs_b_c), .i_waddr(waddr_c),
      .i_wen(wen_c), .i_din(din_c), .i_raddr(raddr_c), .o_dout(dout_c), .o_busy(busy_c));

   typedef struct {
      int          dut;
      int          kind;   // 0 = read port, 1 = busy flag
      int          port;
      logic [31:0] exp;
      string       name;
   } sb_t;

   sb_t sbq[$];
   int  ntot = 0;
   int  nbad = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_rd(input int d, input int p, input logic [31:0] e, input string n);
      sbq.push_back('{d, 0, p, e, n});
   endtask

   task automatic exp_busy(input int d, input logic e, input string n);
      sbq.push_back('{d, 1, 0, {31'h0, e}, n});
   endtask

   // both 32-bit instances, both ports
   task automatic exp_ab(input logic [31:0] ea, input logic [31:0] eb, input string n);
      exp_rd(0, 0, ea, n);
      exp_rd(0, 1, ea, n);
      exp_rd(1, 0, eb, n);
      exp_rd(1, 1, eb, n);
   endtask

   task automatic set_w(input logic c, input logic [3:0] we, input logic [3:0] wa,
                        input logic [31:0] d);
      cs_b  = c;
      wen   = we;
      waddr = wa;
      din   = d;
   endtask

   task automatic set_r(input logic [3:0] r0, input logic [3:0] r1);
      raddr = {r1, r0};
   endtask

   // monitor: reads are combinational, so every pushed expectation is due this cycle
   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         sb_t         it;
         logic [31:0] act;
         it = sbq.pop_front();
         case (it.dut)
            0: act = (it.kind == 1) ? {31'h0, busy_a} : dout_a[it.port*32 +: 32];
            1: act = (it.kind == 1) ? {31'h0, busy_b} : dout_b[it.port*32 +: 32];
            2: act = (it.kind == 1) ? {31'h0, busy_c} : {16'h0, dout_c[it.port*16 +: 16]};
            default: act = 32'hxxxx_xxxx;
         endcase
         ntot++;
         if (act !== it.exp) begin
            nbad++;
            $display("FAIL %s dut%0d kind%0d port%0d got=%h exp=%h",
                     it.name, it.dut, it.kind, it.port, act, it.exp);
         end
      end
   end

   logic [15:0] mdl [8];

   initial begin
      // reset held two edges, then the 16-entry clear
      cyc();
      exp_busy(0, 1'b1, "rst_busy");
      exp_busy(1, 1'b1, "rst_busy");
      cyc();
      rst = 1'b0;
      set_w(1'b0, 4'hF, 4'h2, 32'h5555_AAAA);   // dropped: busy
      set_r(4'h2, 4'h0);
      for (int i = 0; i < 16; i++) begin
         exp_busy(0, 1'b1, "clr_busy");
         exp_busy(1, 1'b1, "clr_busy");
         exp_ab(32'h0, 32'h0, "clr_dout");
         cyc();
      end
      set_w(1'b1, 4'h0, 4'h0, 32'h0);
      exp_busy(0, 1'b0, "clr_done");
      exp_busy(1, 1'b0, "clr_done");
      for (int a = 0; a < 16; a++) begin
         set_r(4'(a), 4'(15 - a));
         exp_ab(32'h0, 32'h0, "post_clr");
         cyc();
      end

      // byte merge on R3
      set_r(4'h3, 4'h3);
      set_w(1'b0, 4'hF, 4'h3, 32'h1122_3344);
      exp_ab(32'h1122_3344, 32'h0, "merge_w1");
      cyc();
      set_w(1'b0, 4'b0101, 4'h3, 32'hAABB_CCDD);
      exp_ab(32'h11BB_33DD, 32'h1122_3344, "merge_w2");
      cyc();
      set_w(1'b1, 4'h0, 4'h0, 32'h0);
      exp_ab(32'h11BB_33DD, 32'h11BB_33DD, "merge_rd");
      cyc();

      // bypass on R5
      set_r(4'h5, 4'h5);
      set_w(1'b0, 4'hF, 4'h5, 32'hDEAD_BEEF);
      exp_ab(32'hDEAD_BEEF, 32'h0, "bypass_w");
      cyc();
      set_w(1'b1, 4'h0, 4'h0, 32'h0);
      exp_ab(32'hDEAD_BEEF, 32'hDEAD_BEEF, "bypass_rd");
      cyc();

      // gated writes to R7
      set_r(4'h7, 4'h3);
      set_w(1'b1, 4'hF, 4'h7, 32'h1234_5678);
      exp_rd(0, 0, 32'h0, "gate_csb");
      exp_rd(1, 0, 32'h0, "gate_csb");
      cyc();
      set_w(1'b0, 4'hF, 4'h7, 32'h1234_5678);
      clk_en = 1'b0;
      exp_rd(0, 0, 32'h0, "gate_ce");
      exp_rd(1, 0, 32'h0, "gate_ce");
      exp_rd(0, 1, 32'h11BB_33DD, "gate_ce_p1");
      cyc();
      clk_en = 1'b1;
      set_w(1'b0, 4'h0, 4'h7, 32'h1234_5678);
      exp_rd(0, 0, 32'h0, "gate_wen");
      exp_rd(1, 0, 32'h0, "gate_wen");
      cyc();
      set_w(1'b1, 4'h0, 4'h0, 32'h0);
      exp_rd(0, 0, 32'h0, "gate_after");
      exp_rd(1, 0, 32'h0, "gate_after");
      cyc();

      // zero register
      set_r(4'h0, 4'h5);
      set_w(1'b0, 4'hF, 4'h0, 32'hFFFF_FFFF);
      exp_rd(0, 0, 32'hFFFF_FFFF, "r0_w");
      exp_rd(1, 0, 32'h0, "r0_w");
      exp_rd(1, 1, 32'hDEAD_BEEF, "r0_w_p1");
      cyc();
      set_w(1'b1, 4'h0, 4'h0, 32'h0);
      exp_rd(0, 0, 32'hFFFF_FFFF, "r0_rd");
      exp_rd(1, 0, 32'h0, "r0_rd");
      cyc();

      // mid-clear reset at ptr=7, then a 3-cycle clk_en stall
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) cyc();
      rst = 1'b1;
      exp_busy(0, 1'b1, "mid_rst");
      exp_busy(1, 1'b1, "mid_rst");
      cyc();
      rst = 1'b0;
      set_r(4'h2, 4'h5);
      for (int i = 0; i < 19; i++) begin
         clk_en = (i >= 4 && i <= 6) ? 1'b0 : 1'b1;
         if (i == 17) set_w(1'b0, 4'hF, 4'h2, 32'hCAFE_F00D);
         else         set_w(1'b1, 4'h0, 4'h0, 32'h0);
         exp_busy(0, 1'b1, "stall_busy");
         exp_busy(1, 1'b1, "stall_busy");
         exp_ab(32'h0, 32'h0, "stall_dout");
         cyc();
      end
      clk_en = 1'b1;
      set_w(1'b1, 4'h0, 4'h0, 32'h0);
      exp_busy(0, 1'b0, "stall_done");
      exp_busy(1, 1'b0, "stall_done");
      exp_ab(32'h0, 32'h0, "reclr_r2_r5");
      cyc();
      set_r(4'h3, 4'h7);
      exp_ab(32'h0, 32'h0, "reclr_r3_r7");
      cyc();

      // narrow 4-port instance: 8-entry clear then randomised traffic against a model
      cyc();
      rst_c = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_busy(2, 1'b1, "c_clr_busy");
         cyc();
      end
      exp_busy(2, 1'b0, "c_clr_done");
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
      for (int n = 0; n < 2000; n++) begin
         logic        w;
         logic [15:0] mg;
         clk_en_c = ($urandom_range(0, 3) != 0);
         cs_b_c   = ($urandom_range(0, 3) == 0);
         waddr_c  = 3'($urandom);
         wen_c    = 2'($urandom);
         din_c    = 16'($urandom);
         raddr_c  = 12'($urandom);
         if (n % 5 == 0) raddr_c[2:0] = waddr_c;
         w  = clk_en_c && !cs_b_c && (wen_c != 2'b00);
         mg = {wen_c[1] ? din_c[15:8] : mdl[waddr_c][15:8],
               wen_c[0] ? din_c[7:0]  : mdl[waddr_c][7:0]};
         for (int p = 0; p < 4; p++) begin
            logic [2:0] ra;
            ra = raddr_c[p*3 +: 3];
            exp_rd(2, p, {16'h0, (w && ra == waddr_c) ? mg : mdl[ra]}, "c_rand");
         end
         cyc();
         if (w) mdl[waddr_c] = mg;
      end
      cs_b_c = 1'b1;
      cyc();
      cyc();
      if (sbq.size() != 0) begin
         nbad++;
         $display("FAIL sb_drain left=%0d exp=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
